// File: rtl/mat_result_streamer_if.sv
// Bus bundle for mat_result_streamer.
//   Capture side : valid_in (one-cycle pulse), result_in (full N x N matrix,
//                  element (r,c) = result_in[r][c]), busy, overflow.
//   Stream side  : out_data/out_row/out_col/out_last qualified by out_valid,
//                  accepted by out_ready.
// Handshake: a beat transfers on a clock edge where out_valid & out_ready are
// both high; while out_valid is high and out_ready is low the producer holds
// out_data/out_row/out_col/out_last stable. The consumer may drive out_ready
// freely; out_valid never depends on out_ready.
// Modports: slave = the streamer itself, master = whoever drives the matrix in
// and consumes the beats.
interface mat_result_streamer_if #(
  parameter int W_OUT = 32,
  parameter int N     = 8
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic                                  valid_in;
  logic signed [N-1:0][N-1:0][W_OUT-1:0] result_in;
  logic                                  busy;
  logic signed [W_OUT-1:0]               out_data;
  logic                                  out_valid;
  logic                                  out_ready;
  logic                                  out_last;
  logic [IW-1:0]                         out_row;
  logic [IW-1:0]                         out_col;
  logic                                  overflow;

  modport slave (
    input  valid_in, result_in, out_ready,
    output busy, out_data, out_valid, out_last, out_row, out_col, overflow
  );

  modport master (
    output valid_in, result_in, out_ready,
    input  busy, out_data, out_valid, out_last, out_row, out_col, overflow
  );
endinterface

// File: rtl/mat_result_streamer.sv
// mat_result_streamer: captures an N x N result matrix on a one-cycle valid
// pulse and streams it out row-major, one element per beat.
// Ports:
//   clk         clock
//   rst         synchronous reset, active-high
//   cen         clock enable / global stall; while low nothing advances and
//               out_valid is held low
//   bus         mat_result_streamer_if.slave (matrix in, beat stream out,
//               busy, sticky overflow)
//   dbg_state_o current FSM state (0 = IDLE, 1 = STREAM)
module mat_result_streamer #(
  parameter int W_OUT = 32,
  parameter int N     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cen,
  mat_result_streamer_if.slave  bus,
  output logic                  dbg_state_o
);
  localparam int            IW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t                        state_q, state_d;
  logic [N-1:0][N-1:0][W_OUT-1:0] buf_q;
  logic [IW-1:0]                 row_q, row_d;
  logic [IW-1:0]                 col_q, col_d;
  logic                          ovf_q, ovf_d;
  logic                          load;
  logic                          streaming;
  logic                          at_last;
  logic                          xfer;

  assign streaming = (state_q == STREAM);
  assign at_last   = (row_q == LAST_IDX) && (col_q == LAST_IDX);
  assign xfer      = streaming && cen && bus.out_ready;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    ovf_d   = ovf_q;
    load    = 1'b0;
    if (cen) begin
      unique case (state_q)
        IDLE: begin
          if (bus.valid_in) begin
            load    = 1'b1;
            state_d = STREAM;
            row_d   = '0;
            col_d   = '0;
          end
        end
        STREAM: begin
          if (xfer) begin
            if (at_last) begin
              row_d = '0;
              col_d = '0;
              // A matrix arriving exactly on the last transfer chains on
              // with no bubble; otherwise the stream ends.
              if (bus.valid_in) load = 1'b1;
              else              state_d = IDLE;
            end else if (col_q == LAST_IDX) begin
              col_d = '0;
              row_d = row_q + IW'(1);
            end else begin
              col_d = col_q + IW'(1);
            end
          end
          // Any other arrival while streaming cannot be buffered: drop it.
          if (bus.valid_in && !(xfer && at_last)) ovf_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      ovf_q   <= ovf_d;
    end
  end

  // Data buffer needs no reset: it is only observed while streaming.
  always_ff @(posedge clk) begin
    if (!rst && load) buf_q <= bus.result_in;
  end

  assign bus.busy      = streaming;
  assign bus.out_valid = streaming && cen;
  assign bus.out_last  = streaming && at_last;
  assign bus.out_data  = streaming ? buf_q[row_q][col_q] : '0;
  assign bus.out_row   = row_q;
  assign bus.out_col   = col_q;
  assign bus.overflow  = ovf_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_mat_result_streamer.sv
module tb_mat_result_streamer;
  localparam int N  = 8;
  localparam int W  = 32;
  localparam int NB = N * N;

  typedef logic [N-1:0][N-1:0][W-1:0] mat_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic cen;
  logic dbg_state;
  always #5 clk = ~clk;

  mat_result_streamer_if #(.W_OUT(W), .N(N)) bus ();

  mat_result_streamer #(.W_OUT(W), .N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .cen         (cen),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- reference model / scoreboard ----------------
  // Pending beats of the accepted matrix, oldest first; beat index is derived
  // from how many remain.
  logic [W-1:0] exp_q[$];
  logic         exp_ovf;
  int           errors = 0;
  int           checks = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic mat_t rnd_mat();
    mat_t m;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        m[r][c] = $urandom;
    return m;
  endfunction

  function automatic mat_t idx_mat();
    mat_t m;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        m[r][c] = W'(r * 16 + c);
    return m;
  endfunction

  // ---------------- driver ----------------
  // Drive one cycle's inputs, check the settled outputs against the model,
  // then advance the model by what the next rising edge should do.
  task automatic cycle(input logic r, input logic c, input logic v,
                       input logic rd, input mat_t m);
    int sz;
    int beat;
    bit xfer;
    rst = r; cen = c; bus.valid_in = v; bus.out_ready = rd; bus.result_in = m;
    #1;
    sz   = exp_q.size();
    beat = (sz == 0) ? 0 : NB - sz;
    chk("out_valid", W'(bus.out_valid), W'(c && sz > 0));
    chk("busy",      W'(bus.busy),      W'(sz > 0));
    chk("out_data",  bus.out_data,      (sz > 0) ? exp_q[0] : '0);
    chk("out_row",   W'(bus.out_row),   W'(beat / N));
    chk("out_col",   W'(bus.out_col),   W'(beat % N));
    chk("out_last",  W'(bus.out_last),  W'(sz == 1));
    chk("overflow",  W'(bus.overflow),  W'(exp_ovf));
    if (r) begin
      exp_q.delete();
      exp_ovf = 1'b0;
    end else if (c) begin
      xfer = rd && (sz > 0);
      if (xfer) void'(exp_q.pop_front());
      if (v) begin
        if (sz == 0 || (xfer && sz == 1)) begin
          for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
              exp_q.push_back(m[i][j]);
        end else begin
          exp_ovf = 1'b1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    while (exp_q.size() > 0) cycle(1'b0, 1'b1, 1'b0, 1'b1, '0);
  endtask

  task automatic run_to_beat(input int b);
    while (exp_q.size() > 0 && (NB - exp_q.size()) < b) cycle(1'b0, 1'b1, 1'b0, 1'b1, '0);
  endtask

  // ---------------- stimulus ----------------
  mat_t ones;
  bit   tog;

  initial begin
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        ones[r][c] = '1;
    rst = 1'b1; cen = 1'b1; bus.valid_in = 1'b0; bus.out_ready = 1'b0; bus.result_in = '0;
    exp_ovf = 1'b0;
    @(negedge clk); @(negedge clk);

    // Reset state held, then idle cycles with no pulse.
    cycle(1'b1, 1'b1, 1'b0, 1'b1, '0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, '0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, '0);

    // Indexed matrix, always ready.
    cycle(1'b0, 1'b1, 1'b1, 1'b1, idx_mat());
    drain();
    cycle(1'b0, 1'b1, 1'b0, 1'b1, '0);

    // Same matrix, ready alternating 1/0.
    cycle(1'b0, 1'b1, 1'b1, 1'b0, idx_mat());
    tog = 1'b1;
    while (exp_q.size() > 0) begin
      cycle(1'b0, 1'b1, 1'b0, tog, '0);
      tog = ~tog;
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b1, '0);

    // Second pulse at beat 10 is dropped and sets sticky overflow.
    cycle(1'b0, 1'b1, 1'b1, 1'b1, idx_mat());
    run_to_beat(10);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, rnd_mat());
    drain();
    cycle(1'b0, 1'b1, 1'b0, 1'b1, '0);

    // Back-to-back: all-ones matrix arrives on the last-beat transfer.
    cycle(1'b1, 1'b1, 1'b0, 1'b1, '0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, rnd_mat());
    while (exp_q.size() > 1) cycle(1'b0, 1'b1, 1'b0, 1'b1, '0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, ones);
    drain();
    cycle(1'b0, 1'b1, 1'b0, 1'b1, '0);

    // Reset at beat 20, then a fresh matrix streams from (0,0).
    cycle(1'b0, 1'b1, 1'b1, 1'b1, rnd_mat());
    run_to_beat(20);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, '0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, '0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, rnd_mat());
    drain();

    // cen low for 5 cycles at beat 30, with valid_in pulses that must be ignored.
    cycle(1'b0, 1'b1, 1'b1, 1'b1, idx_mat());
    run_to_beat(30);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, i[0], 1'b1, rnd_mat());
    drain();
    cycle(1'b0, 1'b1, 1'b0, 1'b1, '0);

    // Random traffic: stalls, back-pressure, stray pulses.
    for (int i = 0; i < 1500; i++) begin
      cycle(1'b0, ($urandom_range(0, 9) != 0), ($urandom_range(0, 29) == 0),
            ($urandom_range(0, 2) != 0), rnd_mat());
    end
    drain();
    cycle(1'b0, 1'b1, 1'b0, 1'b1, '0);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
